// File: rtl/ahb_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arb_pkg
// Brief    : Shared types and constants for the two-master AHB-Lite arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_arb_pkg;

    // AHB-Lite transfer type encoding
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    // Identity of one of the two masters sharing the bus
    typedef enum logic {
        MASTER0 = 1'b0,
        MASTER1 = 1'b1
    } master_id_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // True for transfer types that carry a data phase
    function automatic logic is_active(input htrans_t t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

    // True for transfer types that continue a burst and must not be split
    function automatic logic is_burst_cont(input htrans_t t);
        return (t == SEQ) || (t == BUSY);
    endfunction

endpackage : ahb_arb_pkg
`default_nettype wire

// File: rtl/ahb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_arbiter_if
// Brief    : Bundle of both master-side AHB ports, the shared interconnect
//            port and the per-master grant/ready/response returns.
//            slave  : arbiter view; master : masters + interconnect view.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_master_arbiter_if;
    // master 0 (core wrapper)
    logic        m0_hbusreq;
    logic [31:0] m0_haddr;
    logic [1:0]  m0_htrans;
    logic        m0_hwrite;
    logic [2:0]  m0_hsize;
    logic [3:0]  m0_hprot;
    logic [31:0] m0_hwdata;
    logic        m0_hgrant;
    logic        m0_hready;
    logic        m0_hresp;
    // master 1 (DMA / debug)
    logic        m1_hbusreq;
    logic [31:0] m1_haddr;
    logic [1:0]  m1_htrans;
    logic        m1_hwrite;
    logic [2:0]  m1_hsize;
    logic [3:0]  m1_hprot;
    logic [31:0] m1_hwdata;
    logic        m1_hgrant;
    logic        m1_hready;
    logic        m1_hresp;
    // shared interconnect port
    logic        hready;
    logic        hresp;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hmaster;

    modport slave (
        input  m0_hbusreq, m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hprot, m0_hwdata,
        input  m1_hbusreq, m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hprot, m1_hwdata,
        input  hready, hresp,
        output m0_hgrant, m0_hready, m0_hresp,
        output m1_hgrant, m1_hready, m1_hresp,
        output haddr, htrans, hwrite, hsize, hprot, hwdata, hmaster
    );

    modport master (
        output m0_hbusreq, m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hprot, m0_hwdata,
        output m1_hbusreq, m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hprot, m1_hwdata,
        output hready, hresp,
        input  m0_hgrant, m0_hready, m0_hresp,
        input  m1_hgrant, m1_hready, m1_hresp,
        input  haddr, htrans, hwrite, hsize, hprot, hwdata, hmaster
    );
endinterface : ahb_master_arbiter_if
`default_nettype wire

// File: rtl/ahb_master_arbiter_grant_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arb_grant_fsm
// Brief    : Address-phase grant register and next-grant decision.
//            Round-robin with MAX_HOLD fairness by default; when the macro
//            ARB_FIXED_PRIORITY_EN is defined master 0 has fixed priority and
//            the hold counter is not built.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_arb_grant_fsm
    import ahb_arb_pkg::*;
#(
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       hready,
    input  wire htrans_t    htrans,     // owner's transfer as driven on the bus
    input  wire logic       m0_req,
    input  wire logic       m1_req,
    output master_id_t      grant
);

    localparam master_id_t c_default_id = (DEFAULT_MASTER != 0) ? MASTER1 : MASTER0;

    master_id_t grant_q;
    master_id_t grant_d;
    master_id_t w_peer;
    logic       w_arb_point;

    // A burst in progress (SEQ/BUSY) is never interrupted
    assign w_arb_point = hready && !is_burst_cont(htrans);
    assign w_peer      = master_id_t'(~grant_q);
    assign grant       = grant_q;

`ifdef ARB_FIXED_PRIORITY_EN

    // Next grant: master 0 wins whenever it asks, otherwise master 1, else park
    always_comb begin
        grant_d = grant_q;
        if (w_arb_point) begin
            if (m0_req) begin
                grant_d = MASTER0;
            end else if (m1_req) begin
                grant_d = MASTER1;
            end else begin
                grant_d = c_default_id;
            end
        end
    end

    // Grant register
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= c_default_id;
        end else begin
            grant_q <= grant_d;
        end
    end

`else

    logic [3:0] hold_cnt_q;
    logic [3:0] hold_cnt_d;
    logic [3:0] w_hold_inc;
    logic       w_own_req;
    logic       w_peer_req;

    assign w_own_req  = (grant_q == MASTER0) ? m0_req : m1_req;
    assign w_peer_req = (grant_q == MASTER0) ? m1_req : m0_req;

    // Count including the transfer accepted on this edge, so the owner yields
    // right after its MAX_HOLD-th transfer rather than one transfer later
    assign w_hold_inc = (hready && is_active(htrans) && (hold_cnt_q != 4'hF))
                      ? hold_cnt_q + 4'd1 : hold_cnt_q;

    // Next grant and hold count: keep / hand over / park
    always_comb begin
        grant_d = grant_q;
        if (w_arb_point) begin
            if (w_own_req && (!w_peer_req || (32'(w_hold_inc) < MAX_HOLD))) begin
                grant_d = grant_q;
            end else if (w_peer_req) begin
                grant_d = w_peer;
            end else begin
                grant_d = c_default_id;
            end
        end
        hold_cnt_d = (grant_d != grant_q) ? 4'd0 : w_hold_inc;
    end

    // Grant and hold-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= c_default_id;
            hold_cnt_q <= 4'd0;
        end else begin
            grant_q    <= grant_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`endif

endmodule : ahb_arb_grant_fsm
`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_arbiter
// Brief    : Two-master AHB-Lite arbiter. Address/control follow the
//            address-phase owner, hwdata/response follow the data-phase owner;
//            ungranted masters are stalled through a gated hready.
//            Optional macro: ARB_FIXED_PRIORITY_EN (master 0 fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
module ahb_master_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 8
) (
    input wire logic            clk,
    input wire logic            reset,
    ahb_master_arbiter_if.slave bus
);

    localparam master_id_t c_default_id = (DEFAULT_MASTER != 0) ? MASTER1 : MASTER0;

    master_id_t  w_grant;
    htrans_t     w_htrans;
    logic [31:0] w_haddr;
    logic [1:0]  w_htrans_raw;
    logic        w_hwrite;
    logic [2:0]  w_hsize;
    logic [3:0]  w_hprot;

    master_id_t  downer_q;
    master_id_t  downer_d;
    logic        dvalid_q;
    logic        dvalid_d;

    ahb_arb_grant_fsm #(
        .DEFAULT_MASTER (DEFAULT_MASTER),
        .MAX_HOLD       (MAX_HOLD)
    ) u_grant_fsm (
        .clk    (clk),
        .reset  (reset),
        .hready (bus.hready),
        .htrans (w_htrans),
        .m0_req (bus.m0_hbusreq),
        .m1_req (bus.m1_hbusreq),
        .grant  (w_grant)
    );

    // Address/control mux by address-phase owner; bus held IDLE during reset
    always_comb begin
        w_haddr      = bus.m0_haddr;
        w_htrans_raw = bus.m0_htrans;
        w_hwrite     = bus.m0_hwrite;
        w_hsize      = bus.m0_hsize;
        w_hprot      = bus.m0_hprot;
        if (w_grant == MASTER1) begin
            w_haddr      = bus.m1_haddr;
            w_htrans_raw = bus.m1_htrans;
            w_hwrite     = bus.m1_hwrite;
            w_hsize      = bus.m1_hsize;
            w_hprot      = bus.m1_hprot;
        end
        w_htrans = reset ? IDLE : htrans_t'(w_htrans_raw);
    end

    // Data-phase owner follows the address owner on every completed phase
    always_comb begin
        downer_d = downer_q;
        dvalid_d = dvalid_q;
        if (bus.hready) begin
            downer_d = w_grant;
            dvalid_d = is_active(w_htrans);
        end
    end

    // Data-phase owner registers
    always_ff @(posedge clk) begin
        if (reset) begin
            downer_q <= c_default_id;
            dvalid_q <= 1'b0;
        end else begin
            downer_q <= downer_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign bus.haddr   = w_haddr;
    assign bus.htrans  = w_htrans;
    assign bus.hwrite  = w_hwrite;
    assign bus.hsize   = w_hsize;
    assign bus.hprot   = w_hprot;
    assign bus.hwdata  = (downer_q == MASTER1) ? bus.m1_hwdata : bus.m0_hwdata;
    assign bus.hmaster = w_grant;

    assign bus.m0_hgrant = reset ? (c_default_id == MASTER0) : (w_grant == MASTER0);
    assign bus.m1_hgrant = reset ? (c_default_id == MASTER1) : (w_grant == MASTER1);

    // A master sees ready while it owns the address phase or its data phase
    assign bus.m0_hready = bus.hready &
                           ((w_grant == MASTER0) | ((downer_q == MASTER0) & dvalid_q));
    assign bus.m1_hready = bus.hready &
                           ((w_grant == MASTER1) | ((downer_q == MASTER1) & dvalid_q));

    // Error response only goes to the master whose data phase is active
    assign bus.m0_hresp = !reset & bus.hresp & (downer_q == MASTER0) & dvalid_q;
    assign bus.m1_hresp = !reset & bus.hresp & (downer_q == MASTER1) & dvalid_q;

endmodule : ahb_master_arbiter
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_arbiter
// Brief    : Directed self-checking bench for ahb_master_arbiter
//            (DEFAULT_MASTER=0, MAX_HOLD=8). Fixed-priority scenario is used
//            when ARB_FIXED_PRIORITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_master_arbiter;
    import ahb_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ahb_master_arbiter_if bus ();

    ahb_master_arbiter #(
        .DEFAULT_MASTER (0),
        .MAX_HOLD       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_hbusreq = 1'b0; bus.m0_haddr = '0; bus.m0_htrans = IDLE;
        bus.m0_hwrite  = 1'b0; bus.m0_hsize = HSIZE_WORD; bus.m0_hprot = 4'h3;
        bus.m0_hwdata  = '0;
        bus.m1_hbusreq = 1'b0; bus.m1_haddr = '0; bus.m1_htrans = IDLE;
        bus.m1_hwrite  = 1'b0; bus.m1_hsize = HSIZE_WORD; bus.m1_hprot = 4'h3;
        bus.m1_hwdata  = '0;
        bus.hready     = 1'b1; bus.hresp = 1'b0;
    endtask

    // One reset edge; returns at the start of cycle 0 after reset
    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        reset = 1'b0;
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset behaviour ----------------
        reset = 1'b1;
        idle_inputs();
        bus.m0_hbusreq = 1'b1;
        bus.m0_htrans  = NONSEQ;
        bus.hresp      = 1'b1;
        #2;
        chk("rst_htrans_pre",  32'(bus.htrans),    32'(IDLE));
        chk("rst_m0_hgrant",   32'(bus.m0_hgrant), 32'd1);
        chk("rst_m1_hgrant",   32'(bus.m1_hgrant), 32'd0);
        chk("rst_m0_hresp",    32'(bus.m0_hresp),  32'd0);
        chk("rst_m1_hresp",    32'(bus.m1_hresp),  32'd0);
        next_cycle();
        #1;
        chk("rst_htrans_post", 32'(bus.htrans),    32'(IDLE));
        chk("rst_hmaster",     32'(bus.hmaster),   32'd0);
        chk("rst_m1_hready",   32'(bus.m1_hready), 32'd0);

        // ---------------- M0 single write ----------------
        apply_reset();
        bus.m0_hbusreq = 1'b1; bus.m0_haddr = 32'h1000; bus.m0_htrans = NONSEQ;
        bus.m0_hwrite  = 1'b1; bus.m0_hwdata = 32'h0;
        #2;
        chk("wr_haddr",     bus.haddr,             32'h0000_1000);
        chk("wr_htrans",    32'(bus.htrans),       32'(NONSEQ));
        chk("wr_hwrite",    32'(bus.hwrite),       32'd1);
        chk("wr_m1_hready", 32'(bus.m1_hready),    32'd0);
        next_cycle();
        bus.m0_htrans = IDLE; bus.m0_hbusreq = 1'b0; bus.m0_hwdata = 32'hDEAD_BEEF;
        #2;
        chk("wr_hwdata",    bus.hwdata,            32'hDEAD_BEEF);
        chk("wr_m0_hready", 32'(bus.m0_hready),    32'd1);
        chk("wr_m1_hready2",32'(bus.m1_hready),    32'd0);

`ifndef ARB_FIXED_PRIORITY_EN
        // ---------------- round-robin with MAX_HOLD=8 ----------------
        apply_reset();
        bus.m0_hbusreq = 1'b1; bus.m0_haddr = 32'h2000; bus.m0_htrans = NONSEQ;
        bus.m1_hbusreq = 1'b1; bus.m1_haddr = 32'h3000; bus.m1_htrans = NONSEQ;
        for (int i = 0; i < 24; i++) begin
            logic exp_m;
            exp_m = logic'((i / 8) % 2);
            #2;
            chk($sformatf("rr_hmaster_%0d", i), 32'(bus.hmaster), 32'(exp_m));
            chk($sformatf("rr_haddr_%0d", i),   bus.haddr, exp_m ? 32'h3000 : 32'h2000);
            next_cycle();
        end

        // ---------------- burst is never split ----------------
        // 6 singles, then INCR4 at cycles 6..9 (hold passes MAX_HOLD mid-burst),
        // M1 requests from beat 2; handover only at the IDLE arbitration edge.
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            bus.m0_hbusreq = 1'b1;
            if (c < 6) begin
                bus.m0_htrans = NONSEQ; bus.m0_haddr = 32'h4000 + 32'(c) * 32'h10;
            end else if (c == 6) begin
                bus.m0_htrans = NONSEQ; bus.m0_haddr = 32'h4100;
            end else if (c < 10) begin
                bus.m0_htrans = SEQ;    bus.m0_haddr = 32'h4100 + 32'(c - 6) * 32'h4;
            end else begin
                bus.m0_htrans = IDLE;   bus.m0_haddr = 32'h4200;
            end
            bus.m1_hbusreq = (c >= 7);
            bus.m1_htrans  = (c >= 7) ? NONSEQ : IDLE;
            bus.m1_haddr   = 32'h5000;
            #2;
            if (c >= 7 && c <= 10) begin
                chk($sformatf("burst_hmaster_%0d", c), 32'(bus.hmaster),   32'd0);
                chk($sformatf("burst_m1_hgrant_%0d", c), 32'(bus.m1_hgrant), 32'd0);
            end
            if (c >= 7 && c <= 9) begin
                chk($sformatf("burst_haddr_%0d", c), bus.haddr, 32'h4100 + 32'(c - 6) * 32'h4);
            end
            if (c == 11) begin
                chk("burst_hmaster_after",   32'(bus.hmaster),   32'd1);
                chk("burst_m1_hgrant_after", 32'(bus.m1_hgrant), 32'd1);
                chk("burst_haddr_after",     bus.haddr,          32'h5000);
            end
            next_cycle();
        end
`else
        // ---------------- fixed priority ----------------
        apply_reset();
        bus.m0_hbusreq = 1'b1; bus.m0_haddr = 32'h2000; bus.m0_htrans = NONSEQ;
        bus.m1_hbusreq = 1'b1; bus.m1_haddr = 32'h3000; bus.m1_htrans = NONSEQ;
        for (int i = 0; i < 20; i++) begin
            #2;
            chk($sformatf("fp_hmaster_%0d", i), 32'(bus.hmaster), 32'd0);
            next_cycle();
        end
        bus.m0_hbusreq = 1'b0; bus.m0_htrans = IDLE;
        #2;
        chk("fp_hmaster_drop",  32'(bus.hmaster), 32'd0);
        next_cycle();
        #2;
        chk("fp_hmaster_m1",    32'(bus.hmaster), 32'd1);
        chk("fp_haddr_m1",      bus.haddr,        32'h3000);
        next_cycle();
`endif

        // ---------------- error during handover ----------------
        apply_reset();
        // cycle 0: M0 last transfer, M1 already requesting
        bus.m0_hbusreq = 1'b0; bus.m0_haddr = 32'h6000; bus.m0_htrans = NONSEQ;
        bus.m0_hwrite  = 1'b1;
        bus.m1_hbusreq = 1'b1; bus.m1_haddr = 32'h7000; bus.m1_htrans = NONSEQ;
        bus.m1_hwrite  = 1'b1;
        #2;
        chk("err_hmaster_c0", 32'(bus.hmaster), 32'd0);
        next_cycle();
        // cycles 1,2: wait states; cycle 3: first ERROR cycle; cycle 4: second
        bus.m0_htrans = IDLE;
        bus.m0_hwdata = 32'hCAFE_0000;
        bus.m1_hwdata = 32'h1111_1111;
        for (int c = 1; c <= 4; c++) begin
            bus.hready = (c == 4);
            bus.hresp  = (c >= 3);
            #2;
            chk($sformatf("err_hmaster_c%0d", c), 32'(bus.hmaster), 32'd1);
            chk($sformatf("err_haddr_c%0d", c),   bus.haddr,        32'h7000);
            chk($sformatf("err_m0_hresp_c%0d", c), 32'(bus.m0_hresp), (c >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("err_m1_hresp_c%0d", c), 32'(bus.m1_hresp), 32'd0);
            chk($sformatf("err_m1_hready_c%0d", c), 32'(bus.m1_hready), (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("err_hwdata_c%0d", c),  bus.hwdata,       32'hCAFE_0000);
            next_cycle();
        end
        // cycle 5: M1 data phase
        bus.hready = 1'b1; bus.hresp = 1'b0;
        bus.m1_hbusreq = 1'b0; bus.m1_htrans = IDLE;
        #2;
        chk("err_m0_hready_c5", 32'(bus.m0_hready), 32'd0);
        chk("err_m1_hready_c5", 32'(bus.m1_hready), 32'd1);
        chk("err_hwdata_c5",    bus.hwdata,         32'h1111_1111);
        chk("err_m0_hresp_c5",  32'(bus.m0_hresp),  32'd0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ahb_master_arbiter
`default_nettype wire
